// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with occupancy count, almost flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is a registered 1-cycle-latency read.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic                         rd_en,
    input  logic                         clr_err,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow, r_underflow;
    logic                  w_wr, w_rd;

    assign w_wr         = wr_en && !full;
    assign w_rd         = rd_en && !empty;
    assign count        = r_count;
    assign full         = r_count == CW'(DEPTH);
    assign empty        = r_count == '0;
    assign almost_full  = r_count >= CW'(AF_THRESH);
    assign almost_empty = r_count <= CW'(AE_THRESH);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    always_ff @(posedge clk)
        if (w_wr) r_mem[r_wr_ptr] <= data_in;

    // a new error event on the same edge as clr_err wins over the clear
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_wr != w_rd) r_count <= w_wr ? r_count + CW'(1) : r_count - CW'(1);
            r_overflow  <= (wr_en && full) || (r_overflow && !clr_err);
            r_underflow <= (rd_en && empty) || (r_underflow && !clr_err);
        end

`ifdef SYNC_FIFO_FWFT_EN
    assign data_out = empty ? '0 : r_mem[r_rd_ptr];
`else
    logic [DATA_WIDTH-1:0] r_data_out;

    always_ff @(posedge clk or posedge rst)
        if (rst) r_data_out <= '0;
        else if (w_rd) r_data_out <= r_mem[r_rd_ptr];

    assign data_out = r_data_out;
`endif
endmodule
